mm_access_unit: RTL and testbench
=================================

MM_ACCESS_UNIT -- requirements
Module: mm_access_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port mm_valid, input, 1 bit: an MM1 instruction is present this cycle.
REQ-004 SHALL have ports mm_re and mm_we, input, 1 bit each: load request and store request; both high at once is illegal.
REQ-005 SHALL have port mm_access_sz, input, 2 bits: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-006 SHALL have port mm_ld_unsigned, input, 1 bit: zero-extend load data when high.
REQ-007 SHALL have ports mm_addr and mm_wdata, input, 32 bits each: byte address and store data (right-aligned).
REQ-008 SHALL have port flush, input, 1 bit: kill the current access.
REQ-009 SHALL have bus outputs data_req (1), data_wr (1), data_size (2), data_addr (32, word-aligned), data_wstrb (4) and data_wdata (32).
REQ-010 SHALL have bus inputs data_addr_ok (1), data_data_ok (1) and data_rdata (32).
REQ-011 SHALL have outputs mm_stall (1), mm_done (1), mm_rdata (32) and mm_ale (1, misaligned-address exception).

Function
REQ-012 SHALL implement a finite state machine (FSM) with four states: IDLE, REQ, WAIT, DROP.
REQ-013 SHALL define an access as mm_valid & (mm_re | mm_we).
REQ-014 SHALL flag as misaligned any half access with addr[0]=1, or any word access with addr[1:0]!=0.
REQ-015 SHALL, when misaligned, pulse mm_ale for one cycle, issue no bus request, hold mm_stall low and stay in IDLE.
REQ-016 SHALL, in IDLE with an aligned access and flush low, assert data_req combinationally in the same cycle and go to REQ.
REQ-017 SHALL latch the request on IDLE exit and hold it stable on the bus while in REQ.
REQ-018 SHALL go from REQ to WAIT when data_req & data_addr_ok are both high; data_req SHALL drop in the following cycle.
REQ-019 SHALL treat an addr_ok in the same cycle as the IDLE request as accepted, going IDLE->WAIT directly.
REQ-020 SHALL go from WAIT to IDLE on data_data_ok, pulsing mm_done for one cycle.
REQ-021 SHALL make mm_rdata valid in that mm_done cycle and hold it until the next load completes.
REQ-022 SHALL hold mm_stall high from the first cycle of an access until the cycle after data_data_ok.
REQ-023 SHALL therefore give a minimum latency of 2 cycles: request, then data_ok.
REQ-024 SHALL build store data as: byte {4{wdata[7:0]}} with wstrb=1<<addr[1:0]; half {2{wdata[15:0]}} with wstrb=addr[1]?1100:0011; word wdata with wstrb=1111.
REQ-025 SHALL drive data_wstrb=0000 on loads.
REQ-026 SHALL extract load data from the byte lane data_rdata[8*addr[1:0]+:8], or the half lane [16*addr[1]+:16], then sign- or zero-extend it per mm_ld_unsigned.
REQ-027 SHALL, on flush in IDLE or in REQ before addr_ok, drop the request with no bus effect and return to IDLE.
REQ-028 SHALL, on flush in WAIT or on flush coincident with addr_ok, go to DROP; DROP SHALL wait for data_data_ok, discard the data, assert no mm_done and return to IDLE.
REQ-029 SHALL hold mm_stall low during DROP.
REQ-030 SHALL reject a new access while in DROP: data_req stays low until IDLE.
REQ-031 SHALL ignore data_data_ok in IDLE or REQ (protocol error; no state change).
REQ-032 SHALL ignore the reserved size encoding except for treating it as word.

Reset
REQ-033 SHALL, while rst_n is low, force state=IDLE and data_req, mm_stall, mm_done, mm_ale, data_wstrb=0, and mm_rdata, data_addr, data_wdata=0, immediately and without waiting for a clock edge.
REQ-034 SHALL, after reset is released mid-access, issue no pending transfer; the bus owner is reset by the same rst_n.

Structure
REQ-035 SHALL place the access-size encodings (SZ_B, SZ_H, SZ_W) and the FSM state encodings in the shared defines header.
REQ-036 SHALL contain one natural sub-module, mm_load_align, a combinational lane select plus extension.

Verification
REQ-037 SHALL cover this word load: addr=0x1000, addr_ok in the same cycle, data_ok next cycle with rdata=0xDEADBEEF -> mm_done in cycle 2, mm_rdata=0xDEADBEEF, stall high for 2 cycles.
REQ-038 SHALL cover this byte store: addr=0x1003, wdata=0x000000A5 -> data_wdata=0xA5A5A5A5, wstrb=1000, data_addr=0x1000.
REQ-039 SHALL cover these signed and unsigned half loads: addr=0x2002, rdata=0x8001_1234 -> signed gives mm_rdata=0xFFFF8001, unsigned gives 0x00008001.
REQ-040 SHALL cover this misaligned access: word load at 0x3001 -> mm_ale pulse, data_req never high, stall low.
REQ-041 SHALL cover flush after acceptance: flush in WAIT, then data_ok 3 cycles later -> no mm_done, data_req stays low until back in IDLE, next load issues normally.
REQ-042 SHALL cover backpressure with async reset: addr_ok held low for 5 cycles holds the request stable; rst_n dropped in WAIT clears all outputs asynchronously.

Source files
------------

// File: rtl/mm_access_unit_pkg.sv
// Shared encodings, bus payload type and helpers for the MM1 load/store access unit.
package mm_access_unit_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned STRB_W = 4;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DROP = 2'b11
    } state_e;

    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] wstrb;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    // The reserved encoding behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        return (sz == SZ_RSV) ? SZ_W : sz;
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
        case (norm_size(sz))
            SZ_H:    return lo[0];
            SZ_W:    return (lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    // Word-aligned bus request with store data replicated across the addressed lanes.
    function automatic bus_req_t build_req(input logic we, input logic [1:0] sz,
                                           input logic [ADDR_W-1:0] addr,
                                           input logic [DATA_W-1:0] wdata);
        bus_req_t r;
        r      = '0;
        r.wr   = we;
        r.size = norm_size(sz);
        r.addr = {addr[ADDR_W-1:2], 2'b00};
        case (r.size)
            SZ_B: begin
                r.wdata = {4{wdata[7:0]}};
                r.wstrb = STRB_W'(4'b0001 << addr[1:0]);
            end
            SZ_H: begin
                r.wdata = {2{wdata[15:0]}};
                r.wstrb = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                r.wdata = wdata;
                r.wstrb = 4'b1111;
            end
        endcase
        if (!we) begin
            r.wstrb = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/mm_access_unit_load_align.sv
// Load-data lane select plus sign/zero extension.
module mm_load_align
    import mm_access_unit_pkg::*;
(
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_addr_lo,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    output logic [DATA_W-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (norm_size(i_size))
            SZ_B:    o_data = i_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_H:    o_data = i_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mm_access_unit.sv
// MM1 load/store access unit: issues one bus transfer per access, handles flush and misalignment.
module mm_access_unit
    import mm_access_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mm_valid,
    input  logic              mm_re,
    input  logic              mm_we,
    input  logic [1:0]        mm_access_sz,
    input  logic              mm_ld_unsigned,
    input  logic [ADDR_W-1:0] mm_addr,
    input  logic [DATA_W-1:0] mm_wdata,
    input  logic              flush,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [STRB_W-1:0] data_wstrb,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic              mm_stall,
    output logic              mm_done,
    output logic [DATA_W-1:0] mm_rdata,
    output logic              mm_ale
);

    state_e            r_state;
    state_e            w_next;
    bus_req_t          r_req;
    bus_req_t          w_new_req;
    bus_req_t          w_bus;
    logic [1:0]        r_addr_lo;
    logic              r_ld_unsigned;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_ld_data;
    logic              w_access;
    logic              w_misalign;
    logic              w_issue;
    logic              w_done;

    // Access decode; gating with rst_n keeps the bus quiet while reset is held.
    always_comb begin
        w_access   = rst_n & mm_valid & (mm_re | mm_we);
        w_misalign = misaligned(mm_access_sz, mm_addr[1:0]);
        w_new_req  = build_req(mm_we, mm_access_sz, mm_addr, mm_wdata);
        w_issue    = (r_state == ST_IDLE) & w_access & ~w_misalign & ~flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_next = data_addr_ok ? ST_WAIT : ST_REQ;
                end
            end
            ST_REQ: begin
                if (data_addr_ok) begin
                    w_next = flush ? ST_DROP : ST_WAIT;
                end else if (flush) begin
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Data arriving with the flush completes the transfer, so no DROP is needed.
                if (data_data_ok) begin
                    w_next = ST_IDLE;
                end else if (flush) begin
                    w_next = ST_DROP;
                end
            end
            ST_DROP: begin
                if (data_data_ok) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        data_req = 1'b0;
        mm_stall = 1'b0;
        mm_ale   = 1'b0;
        w_done   = 1'b0;
        w_bus    = r_req;
        case (r_state)
            ST_IDLE: begin
                data_req = w_issue;
                mm_stall = w_issue;
                mm_ale   = w_access & w_misalign & ~flush;
                if (w_issue) begin
                    w_bus = w_new_req;
                end
            end
            ST_REQ: begin
                data_req = 1'b1;
                mm_stall = 1'b1;
            end
            ST_WAIT: begin
                mm_stall = 1'b1;
                w_done   = data_data_ok & ~flush;
            end
            default: ;
        endcase
        data_wr    = w_bus.wr;
        data_size  = w_bus.size;
        data_addr  = w_bus.addr;
        data_wdata = w_bus.wdata;
        data_wstrb = data_req ? w_bus.wstrb : '0;
        mm_done    = w_done;
        mm_rdata   = (w_done & ~r_req.wr) ? w_ld_data : r_rdata;
    end

    // Request is captured on IDLE exit so the bus stays stable while waiting for addr_ok.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req         <= '0;
            r_addr_lo     <= 2'b00;
            r_ld_unsigned <= 1'b0;
            r_rdata       <= '0;
        end else begin
            if (w_issue) begin
                r_req         <= w_new_req;
                r_addr_lo     <= mm_addr[1:0];
                r_ld_unsigned <= mm_ld_unsigned;
            end
            if (w_done & ~r_req.wr) begin
                r_rdata <= w_ld_data;
            end
        end
    end

    mm_load_align u_load_align (
        .i_rdata    (data_rdata),
        .i_addr_lo  (r_addr_lo),
        .i_size     (r_req.size),
        .i_unsigned (r_ld_unsigned),
        .o_data     (w_ld_data)
    );

endmodule

// File: tb/tb_mm_access_unit.sv
// Scoreboard bench for mm_access_unit: stimulus queues expectations, a negedge monitor checks them.
module tb_mm_access_unit;

    logic        clk;
    logic        rst_n;
    logic        mm_valid, mm_re, mm_we, mm_ld_unsigned, flush;
    logic [1:0]  mm_access_sz;
    logic [31:0] mm_addr, mm_wdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata, mm_rdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic        mm_stall, mm_done, mm_ale;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } breq_t;

    breq_t       bq[$];
    logic [31:0] dq[$];
    breq_t       mon_e;
    logic [31:0] last_ld;
    logic        exp_stall, exp_done, exp_ale;
    int          n_chk;
    int          n_fail;

    mm_access_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mm_valid       (mm_valid),
        .mm_re          (mm_re),
        .mm_we          (mm_we),
        .mm_access_sz   (mm_access_sz),
        .mm_ld_unsigned (mm_ld_unsigned),
        .mm_addr        (mm_addr),
        .mm_wdata       (mm_wdata),
        .flush          (flush),
        .data_req       (data_req),
        .data_wr        (data_wr),
        .data_size      (data_size),
        .data_addr      (data_addr),
        .data_wstrb     (data_wstrb),
        .data_wdata     (data_wdata),
        .data_addr_ok   (data_addr_ok),
        .data_data_ok   (data_data_ok),
        .data_rdata     (data_rdata),
        .mm_stall       (mm_stall),
        .mm_done        (mm_done),
        .mm_rdata       (mm_rdata),
        .mm_ale         (mm_ale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name, input logic [31:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %h with nothing expected (t=%0t)", name, act, $time);
    endtask

    // Reference model: byte count, lane offset and plain arithmetic on the address.
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic model_misaligned(input logic [1:0] sz, input logic [31:0] a);
        int off;
        off = int'(a[1:0]);
        return (off % nbytes(sz)) != 0;
    endfunction

    function automatic breq_t model_req(input logic we, input logic [1:0] sz,
                                        input logic [31:0] a, input logic [31:0] wd);
        breq_t r;
        int    n;
        int    off;
        n      = nbytes(sz);
        off    = int'(a[1:0]);
        r      = '0;
        r.wr   = we;
        r.addr = a - 32'(off);
        r.size = (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
        for (int i = 0; i < 4; i++) begin
            r.wstrb[i] = we && (i >= off) && (i < off + n);
        end
        if (n == 1)      r.wdata = (wd & 32'hFF) * 32'h0101_0101;
        else if (n == 2) r.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
        else             r.wdata = wd;
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] a,
                                               input logic [31:0] rd, input logic uns);
        logic [31:0] m;
        logic [31:0] v;
        int          n;
        n = nbytes(sz);
        if (n == 4) return rd;
        m = (n == 1) ? 32'hFF : 32'hFFFF;
        v = (rd >> (8 * int'(a[1:0]))) & m;
        if (!uns && ((v & ((m >> 1) + 32'd1)) != 0)) v = v | ~m;
        return v;
    endfunction

    always @(negedge clk) begin
        chk("stall", 32'(mm_stall), 32'(exp_stall));
        chk("done", 32'(mm_done), 32'(exp_done));
        chk("ale", 32'(mm_ale), 32'(exp_ale));
        if (data_req) begin
            if (bq.size() == 0) begin
                note_fail("unexpected_req", data_addr);
            end else begin
                mon_e = bq[0];
                chk("bus_addr", data_addr, mon_e.addr);
                chk("bus_wr", 32'(data_wr), 32'(mon_e.wr));
                chk("bus_size", 32'(data_size), 32'(mon_e.size));
                chk("bus_wstrb", 32'(data_wstrb), 32'(mon_e.wstrb));
                if (mon_e.wr) chk("bus_wdata", data_wdata, mon_e.wdata);
                if (data_addr_ok) bq.delete(0);
            end
        end
        if (mm_done) begin
            if (dq.size() == 0) begin
                note_fail("unexpected_done", mm_rdata);
            end else begin
                chk("mm_rdata", mm_rdata, dq[0]);
                dq.delete(0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_vals();
        mm_valid     = 1'b0;
        mm_re        = 1'b0;
        mm_we        = 1'b0;
        flush        = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = $urandom;
        exp_stall    = 1'b0;
        exp_done     = 1'b0;
        exp_ale      = 1'b0;
    endtask

    task automatic idle();
        step();
        idle_vals();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"}, 32'(data_req), 32'd0);
        chk({tag, "_stall"}, 32'(mm_stall), 32'd0);
        chk({tag, "_done"}, 32'(mm_done), 32'd0);
        chk({tag, "_ale"}, 32'(mm_ale), 32'd0);
        chk({tag, "_wstrb"}, 32'(data_wstrb), 32'd0);
        chk({tag, "_rdata"}, mm_rdata, 32'd0);
        chk({tag, "_addr"}, data_addr, 32'd0);
        chk({tag, "_wdata"}, data_wdata, 32'd0);
    endtask

    // Flushed transfer: data still comes back but must be swallowed; new accesses are refused.
    task automatic drop_phase(input int dlat, input logic drop_try);
        for (int j = 0; j < dlat; j++) begin
            idle();
            if (drop_try) begin
                mm_valid     = 1'b1;
                mm_re        = 1'b1;
                mm_access_sz = 2'd2;
                mm_addr      = 32'h0000_6000;
            end
        end
        idle();
        data_data_ok = 1'b1;
        idle();
    endtask

    // fmode: 0 normal, 1 flush in REQ before addr_ok, 2 flush with addr_ok, 3 flush in WAIT.
    task automatic run_access(input logic we, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] wd, input logic uns, input int alat,
                              input int dlat, input logic [31:0] rd, input int fmode,
                              input int fdelay, input logic drop_try);
        breq_t e;
        e = model_req(we, sz, a, wd);
        idle();
        mm_valid       = 1'b1;
        mm_re          = ~we;
        mm_we          = we;
        mm_access_sz   = sz;
        mm_addr        = a;
        mm_wdata       = wd;
        mm_ld_unsigned = uns;
        if (model_misaligned(sz, a)) begin
            exp_ale      = 1'b1;
            data_addr_ok = 1'($urandom_range(0, 1));
            idle();
            return;
        end
        bq.push_back(e);
        exp_stall    = 1'b1;
        data_addr_ok = (alat == 0);
        if (fmode == 0) begin
            if (!we) last_ld = model_load(sz, a, rd, uns);
            dq.push_back(last_ld);
        end
        for (int k = 1; k <= alat; k++) begin
            idle();
            exp_stall = 1'b1;
            if (fmode == 1 && k == fdelay) begin
                flush = 1'b1;
                idle();
                bq.delete(0);
                return;
            end
            data_addr_ok = (k == alat);
            flush        = (fmode == 2 && k == alat);
        end
        if (fmode == 2) begin
            drop_phase(dlat, drop_try);
            return;
        end
        if (fmode == 3) begin
            idle();
            flush     = 1'b1;
            exp_stall = 1'b1;
            drop_phase(dlat, drop_try);
            return;
        end
        for (int j = 0; j < dlat; j++) begin
            idle();
            exp_stall = 1'b1;
        end
        idle();
        exp_stall    = 1'b1;
        exp_done     = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = rd;
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        breq_t e;
        n_chk          = 0;
        n_fail         = 0;
        last_ld        = 32'd0;
        rst_n          = 1'b0;
        mm_access_sz   = 2'd0;
        mm_addr        = 32'd0;
        mm_wdata       = 32'd0;
        mm_ld_unsigned = 1'b0;
        idle_vals();
        #3;
        check_all_zero("reset");
        step();
        step();
        rst_n = 1'b1;

        run_access(1'b0, 2'd2, 32'h0000_1000, 32'd0, 1'b0, 0, 0, 32'hDEAD_BEEF, 0, 1, 1'b0);
        run_access(1'b1, 2'd0, 32'h0000_1003, 32'h0000_00A5, 1'b0, 1, 1, 32'd0, 0, 1, 1'b0);
        run_access(1'b0, 2'd1, 32'h0000_2002, 32'd0, 1'b0, 0, 1, 32'h8001_1234, 0, 1, 1'b0);
        run_access(1'b0, 2'd1, 32'h0000_2002, 32'd0, 1'b1, 2, 0, 32'h8001_1234, 0, 1, 1'b0);
        run_access(1'b0, 2'd2, 32'h0000_3001, 32'd0, 1'b0, 0, 0, 32'd0, 0, 1, 1'b0);
        run_access(1'b0, 2'd2, 32'h0000_4000, 32'd0, 1'b0, 1, 2, 32'd0, 3, 1, 1'b1);
        run_access(1'b0, 2'd2, 32'h0000_4004, 32'd0, 1'b0, 0, 0, 32'h1357_9BDF, 0, 1, 1'b0);
        run_access(1'b1, 2'd3, 32'h0000_4008, 32'hCAFE_F00D, 1'b0, 3, 1, 32'd0, 1, 2, 1'b0);
        run_access(1'b0, 2'd0, 32'h0000_400B, 32'd0, 1'b0, 2, 1, 32'd0, 2, 1, 1'b1);
        run_access(1'b1, 2'd1, 32'h0000_400E, 32'h0000_BEEF, 1'b0, 0, 0, 32'd0, 0, 1, 1'b0);

        // Flush in IDLE plus a stray data_ok: nothing may happen.
        idle();
        mm_valid     = 1'b1;
        mm_re        = 1'b1;
        mm_access_sz = 2'd2;
        mm_addr      = 32'h0000_7000;
        flush        = 1'b1;
        data_data_ok = 1'b1;
        idle();
        run_access(1'b0, 2'd0, 32'h0000_7001, 32'd0, 1'b0, 0, 2, 32'h0000_8000, 0, 1, 1'b0);

        for (int i = 0; i < 200; i++) begin
            logic        we;
            logic [1:0]  sz;
            logic [31:0] a;
            int          al, dl, fm, fd, n;
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            n  = nbytes(sz);
            if ($urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
            al = int'($urandom_range(0, 3));
            dl = int'($urandom_range(0, 3));
            fm = int'($urandom_range(0, 9));
            fd = 1;
            if (fm <= 6) begin
                fm = 0;
            end else if (fm == 7) begin
                fm = 1;
                if (al < 2) al = 2;
                fd = int'($urandom_range(1, al - 1));
            end else if (fm == 8) begin
                fm = 2;
                if (al < 1) al = 1;
            end else begin
                fm = 3;
            end
            run_access(we, sz, a, $urandom, 1'($urandom_range(0, 1)), al, dl, $urandom,
                       fm, fd, 1'($urandom_range(0, 1)));
        end

        // Backpressure for 5 cycles, then async reset while waiting for data.
        e = model_req(1'b0, 2'd2, 32'h0000_5000, 32'd0);
        idle();
        mm_valid     = 1'b1;
        mm_re        = 1'b1;
        mm_access_sz = 2'd2;
        mm_addr      = 32'h0000_5000;
        bq.push_back(e);
        exp_stall = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            idle();
            exp_stall    = 1'b1;
            data_addr_ok = (k == 5);
        end
        idle();
        exp_stall = 1'b1;
        #2;
        rst_n        = 1'b0;
        exp_stall    = 1'b0;
        mm_valid     = 1'b1;
        mm_re        = 1'b1;
        mm_addr      = 32'h0000_5004;
        #1;
        check_all_zero("async_rst");
        last_ld = 32'd0;
        idle();
        idle();
        rst_n = 1'b1;
        idle();
        idle();
        run_access(1'b0, 2'd1, 32'h0000_5006, 32'd0, 1'b0, 1, 0, 32'h7FFF_0000, 0, 1, 1'b0);
        idle();
        idle();

        chk("pending_bus_reqs", 32'(bq.size()), 32'd0);
        chk("pending_dones", 32'(dq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
